// File: rtl/regfile_mp.sv
// Multi-port register file with byte-lane strobes, optional hardwired zero
// register, optional write-to-read bypass and a one-register-per-cycle clear engine.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NREAD*$clog2(DEPTH)-1:0]    ra,
  output logic [NREAD*WIDTH-1:0]            rd,
  input  logic [NWRITE-1:0]                 we,
  input  logic [NWRITE*$clog2(DEPTH)-1:0]   wa,
  input  logic [NWRITE*WIDTH-1:0]           wd,
  input  logic [NWRITE*(WIDTH/8)-1:0]       wstrb,
  input  logic                              clr_req,
  output logic                              busy,
  output logic                              clr_done
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              NB        = WIDTH / 8;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);
  localparam bit              ZERO_EN   = (ZERO_REG != 0);
  localparam bit              BYPASS_EN = (BYPASS != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [AW-1:0]     cnt_r;
  logic [AW-1:0]     cnt_nxt_s;
  logic              busy_r;
  logic              busy_nxt_s;
  logic              clr_done_r;
  logic              clr_done_nxt_s;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [WIDTH-1:0]  nxt_s [DEPTH];
  logic [7:0]        lane_s;
  logic              wr_ok_s;
  logic [AW-1:0]     raddr_s;

  assign busy     = busy_r;
  assign clr_done = clr_done_r;

  // Clear engine: next state, sweep counter and the completion pulse
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    clr_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {AW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_CLEAR: begin
        // a new clr_req here is ignored: the sweep never restarts
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s    = ST_IDLE;
          cnt_nxt_s      = {AW{1'b0}};
          clr_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = cnt_r + AW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {AW{1'b0}};
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_CLEAR);
  end

  // Clear engine state and its registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {AW{1'b0}};
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      busy_r     <= busy_nxt_s;
      clr_done_r <= clr_done_nxt_s;
    end
  end

  assign wr_ok_s = (state_r == ST_IDLE);

  // Post-edge value of every register, lane by lane; higher ports override lower
  always_comb begin
    lane_s = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < NB; b++) begin
        lane_s = mem_r[i][b*8 +: 8];
        for (int p = 0; p < NWRITE; p++) begin
          lane_s = (wr_ok_s && we[p] && wstrb[p*NB + b] && (wa[p*AW +: AW] == AW'(i)))
                   ? wd[p*WIDTH + b*8 +: 8] : lane_s;
        end
        lane_s = (((state_r == ST_CLEAR) && (cnt_r == AW'(i))) || (ZERO_EN && (i == 32'sd0)))
                 ? 8'h00 : lane_s;
        nxt_s[i][b*8 +: 8] = lane_s;
      end
    end
  end

  // Register array storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= nxt_s[i];
      end
    end
  end

  // Combinational read ports; forwarding is disabled during a clear and in reset
  always_comb begin
    rd      = {(NREAD*WIDTH){1'b0}};
    raddr_s = {AW{1'b0}};
    for (int r = 0; r < NREAD; r++) begin
      raddr_s = ra[r*AW +: AW];
      if (ZERO_EN && (raddr_s == {AW{1'b0}})) begin
        rd[r*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else if (BYPASS_EN && !busy_r && reset_n) begin
        rd[r*WIDTH +: WIDTH] = nxt_s[raddr_s];
      end else begin
        rd[r*WIDTH +: WIDTH] = mem_r[raddr_s];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a non-bypass and a bypass instance share stimulus and are
// both checked against an array-based model of the register file and clear sweep.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NB = W / 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR*AW-1:0]  ra;
  logic [NR*W-1:0]   rd_a, rd_b;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  wa;
  logic [NW*W-1:0]   wd;
  logic [NW*NB-1:0]  wstrb;
  logic              clr_req;
  logic              busy_a, busy_b, clr_done_a, clr_done_b;

  logic [W-1:0] m_mem [D];
  logic [W-1:0] m_nxt [D];
  int           m_clr;     // index being cleared this cycle, -1 when idle
  logic         m_done;
  int           nchk, nfail;
  int           nbusy, ndone;
  logic [W-1:0] saved;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .BYPASS(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_a), .we(we), .wa(wa), .wd(wd),
    .wstrb(wstrb), .clr_req(clr_req), .busy(busy_a), .clr_done(clr_done_a));

  regfile_mp #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_b), .we(we), .wa(wa), .wd(wd),
    .wstrb(wstrb), .clr_req(clr_req), .busy(busy_b), .clr_done(clr_done_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_clr  = -1;
    m_done = 1'b0;
  endtask

  // value each register will hold after the coming edge, from the current inputs
  task automatic model_next();
    for (int i = 0; i < D; i++) m_nxt[i] = m_mem[i];
    if (m_clr >= 0) begin
      m_nxt[m_clr] = '0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (we[p])
          for (int b = 0; b < NB; b++)
            if (wstrb[p*NB + b]) m_nxt[wa[p*AW +: AW]][b*8 +: 8] = wd[p*W + b*8 +: 8];
    end
    m_nxt[0] = '0;
  endtask

  task automatic check_reads(input string ph);
    logic [AW-1:0] a;
    for (int r = 0; r < NR; r++) begin
      a = ra[r*AW +: AW];
      chk($sformatf("%s plain rd%0d reg%0d", ph, r, a), rd_a[r*W +: W], m_mem[a]);
      chk($sformatf("%s bypass rd%0d reg%0d", ph, r, a), rd_b[r*W +: W],
          (m_clr >= 0) ? m_mem[a] : m_nxt[a]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_next();
    check_reads("pre");
    @(posedge clk);
    for (int i = 0; i < D; i++) m_mem[i] = m_nxt[i];
    m_done = 1'b0;
    if (m_clr >= 0) begin
      if (m_clr == D - 1) begin
        m_clr  = -1;
        m_done = 1'b1;
      end else begin
        m_clr++;
      end
    end else if (clr_req) begin
      m_clr = 0;
    end
    #1;
    chk("busy plain", busy_a, (m_clr >= 0));
    chk("busy bypass", busy_b, (m_clr >= 0));
    chk("clr_done plain", clr_done_a, m_done);
    chk("clr_done bypass", clr_done_b, m_done);
    if (busy_a) nbusy++;
    if (clr_done_a) ndone++;
    model_next();
    check_reads("post");
  endtask

  // sweep all addresses with no writes pending; only used while idle or in reset
  task automatic check_all(input string ph);
    we      = '0;
    clr_req = 1'b0;
    for (int a = 0; a < D; a++) begin
      ra = {AW'(D - 1 - a), AW'(a)};
      #1;
      model_next();
      check_reads(ph);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    we    = 2'($urandom);
    wa    = ($urandom_range(0, 1) == 0) ? {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))}
                                        : 10'($urandom);
    wd    = {$urandom, $urandom};
    wstrb = 8'($urandom);
    ra    = ($urandom_range(0, 1) == 0) ? {wa[AW +: AW], wa[0 +: AW]} : 10'($urandom);
  endtask

  initial begin
    nchk = 0; nfail = 0; nbusy = 0; ndone = 0;
    reset_n = 1'b0; we = '0; wa = '0; wd = '0; wstrb = '0; ra = '0; clr_req = 1'b0;
    model_reset();
    #1;
    chk("reset busy", busy_a, 1'b0);
    chk("reset clr_done", clr_done_a, 1'b0);
    check_all("reset");
    reset_n = 1'b1;

    // single write, read back on both ports
    we = 2'b01; wa = {5'd0, 5'd2}; wstrb = 8'h0F; wd = {32'h0, 32'hDEADBEEF}; ra = {5'd1, 5'd2};
    cycle();
    chk("default rd0", rd_a[31:0], 32'hDEADBEEF);
    chk("default rd1", rd_a[63:32], 32'h0);

    // two ports on one register, per-lane priority to port 1
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'h2222ABCD, 32'h11111111}; wstrb = 8'hCF; ra = {5'd5, 5'd5};
    cycle();
    chk("conflict reg5", rd_a[31:0], 32'h22221111);

    // register 0 ignores writes
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hAAAAAAAA}; wstrb = 8'h0F; ra = {5'd0, 5'd0};
    cycle();
    chk("zero reg plain", rd_a[31:0], 32'h0);
    chk("zero reg bypass", rd_b[31:0], 32'h0);

    // bypass shows the incoming value before the edge
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'h0, 32'h12345678}; ra = {5'd0, 5'd7};
    #1;
    chk("bypass early", rd_b[31:0], 32'h12345678);
    chk("no bypass early", rd_a[31:0], m_mem[7]);
    cycle();

    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      cycle();
    end

    // fill then clear, with a write alongside the request and one during the sweep
    for (int a = 1; a < D; a++) begin
      we = 2'b01; wa = {5'd0, AW'(a)}; wd = {32'h0, $urandom}; wstrb = 8'h0F; ra = 10'($urandom);
      cycle();
    end
    saved = $urandom;
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, saved}; wstrb = 8'h0F; clr_req = 1'b1;
    nbusy = 0; ndone = 0;
    cycle();
    ra = {5'd9, 5'd9};
    #1;
    chk("write with clr_req", rd_a[31:0], saved);
    for (int k = 1; k <= 33; k++) begin
      rand_inputs();
      we      = (k == 3) ? 2'b11 : 2'b00;
      clr_req = (k == 5);
      cycle();
    end
    clr_req = 1'b0;
    chk("busy cycles", nbusy, 32);
    chk("clr_done pulses", ndone, 1);
    check_all("cleared");

    // random traffic with occasional clears
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      clr_req = ($urandom_range(0, 39) == 0);
      cycle();
    end
    clr_req = 1'b0; we = '0;
    for (int n = 0; n < 40; n++) cycle();

    // reset in the middle of a clear
    for (int a = 1; a < D; a += 3) begin
      we = 2'b01; wa = {5'd0, AW'(a)}; wd = {32'h0, $urandom}; wstrb = 8'h0F;
      cycle();
    end
    we = '0; clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    for (int k = 1; k < 10; k++) begin
      ra = 10'($urandom);
      cycle();
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("abort busy", busy_a, 1'b0);
    chk("abort busy bypass", busy_b, 1'b0);
    chk("abort clr_done", clr_done_a, 1'b0);
    check_all("abort");
    reset_n = 1'b1;
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hCAFEF00D}; wstrb = 8'h0F; ra = {5'd0, 5'd3};
    cycle();
    chk("first write after reset", rd_a[31:0], 32'hCAFEF00D);
    we = '0; ndone = 0;
    for (int n = 0; n < 34; n++) cycle();
    chk("no clr_done after abort", ndone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 32, number of registers; SHALL be a power of 2, AW = log2(DEPTH).
REQ-003 Parameter NREAD, default 2, number of read ports.
REQ-004 Parameter NWRITE, default 2, number of write ports.
REQ-005 Parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-006 Parameter BYPASS, default 0; when 1, same-cycle writes forward to reads.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 ra  in  NREAD*AW  read addresses; port r occupies bits [r*AW +: AW].
REQ-010 rd  out  NREAD*WIDTH  read data; port r occupies bits [r*WIDTH +: WIDTH].
REQ-011 we  in  NWRITE  per-port write enable.
REQ-012 wa  in  NWRITE*AW  write addresses.
REQ-013 wd  in  NWRITE*WIDTH  write data.
REQ-014 wstrb  in  NWRITE*(WIDTH/8)  per-port byte-lane strobes.
REQ-015 clr_req  in  1  single-cycle request to start a sequential clear of all registers.
REQ-016 busy  out  1  high while a clear is in progress.
REQ-017 clr_done  out  1  one-cycle pulse when a clear completes.

Function
REQ-018 Reads SHALL be combinational: rd[r] = contents of register ra[r], with no clock latency.
REQ-019 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of writes or bypass.
REQ-020 Writes SHALL take effect on the rising edge; port p updates byte lane b of reg[wa[p]] only when we[p]=1 and wstrb[p][b]=1.
REQ-021 When several ports address the same register, each byte lane SHALL take the data of the highest-index port with we and strobe set for that lane.
REQ-022 With BYPASS=1, rd[r] SHALL equal the value reg[ra[r]] will hold after the current edge, merged per REQ-021; with BYPASS=0, rd[r] SHALL show the pre-edge value.
REQ-023 The FSM SHALL have two states, IDLE and CLEAR; it SHALL enter CLEAR from IDLE on clr_req=1 and load an AW-bit counter with 0.
REQ-024 In CLEAR, one register SHALL be zeroed per cycle at the counter address, and the counter SHALL then increment.
REQ-025 After zeroing register DEPTH-1, the FSM SHALL return to IDLE and pulse clr_done for exactly one cycle; a clear lasts DEPTH cycles.
REQ-026 busy SHALL equal 1 exactly while the state is CLEAR.
REQ-027 clr_req while in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-028 All port writes presented while busy=1 SHALL be discarded.
REQ-029 Reads during CLEAR SHALL return current contents: 0 for registers already cleared and old data for registers not yet cleared.
REQ-030 Bypass SHALL be suppressed while busy=1.
REQ-031 clr_req coinciding with port writes in IDLE SHALL let those writes complete on that edge; the clear starts on the next cycle.

Reset
REQ-032 reset_n=0 SHALL immediately, without waiting for a clock edge, zero all registers, set state IDLE, counter 0, busy 0 and clr_done 0.
REQ-033 Reset asserted during CLEAR SHALL abort the clear without generating a clr_done pulse.
REQ-034 After reset_n deasserts, the block SHALL accept writes on the first rising edge.

Verification
REQ-035 Defaults: we=01, wa[0]=2, wstrb=F, wd=DEADBEEF, ra[0]=2 -> rd[0]=DEADBEEF after the edge; ra[1]=1 -> rd[1]=0.
REQ-036 Conflict: port0 writes 11111111 and port1 writes 2222xxxx with wstrb[1]=1100, both to reg 5 -> reg5 = 22221111.
REQ-037 ZERO_REG: write AAAAAAAA to reg 0 -> rd for reg 0 = 0; BYPASS=1: write 12345678 to reg 7 with ra=7 in the same cycle -> rd=12345678 before the edge.
REQ-038 Clear: fill regs 1..31, pulse clr_req -> busy high for 32 cycles, a write issued at cycle 3 is discarded, clr_done pulses once, all regs read 0.
REQ-039 Reset mid-clear: assert reset_n=0 at cycle 10 of a clear -> busy drops asynchronously, clr_done never pulses, all regs read 0.
